// File: rtl/decode_frontend.sv
// Decode front end: one-entry decode stage between fetch and execute.
// Optional perf counters are built only when DECODE_PERF_EN is defined.
module decode_frontend (
   input  logic        clk,
   input  logic        rstn,
   input  logic        FD_valid,
   input  logic [32:0] FD_BUS,
   input  logic [31:0] inst_sram_rdata,
   input  logic        D_flush,
   input  logic        E_allowin,
   output logic        D_allowin,
   output logic        DE_valid,
   output logic [63:0] DE_BUS,
   output logic [31:0] perf_issue_cnt,
   output logic [31:0] perf_stall_cnt
);

   // state    | meaning
   // EMPTY    | no instruction in decode
   // FRESH    | first cycle after accept, inst comes live from the SRAM
   // HELD     | stalled, inst comes from inst_hold_q
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_FRESH = 2'd1;
   localparam logic [1:0] ST_HELD  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_hold_q, inst_hold_d;
   logic        d_valid;
   logic        d_ready_go;
   logic        accept;
   logic        take;
   logic [31:0] d_inst;

   assign d_valid    = (state_q == ST_FRESH) || (state_q == ST_HELD);
   assign d_ready_go = 1'b1;
   // While rstn is low the stage is treated as empty so fetch never sees backpressure.
   assign D_allowin  = !rstn || !d_valid || (d_ready_go && E_allowin);
   assign accept     = FD_valid && FD_BUS[0] && D_allowin;
   assign take       = accept && !D_flush;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      inst_hold_d = inst_hold_q;
      if (take) begin
         pc_d = FD_BUS[32:1];
      end
      if (D_flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: state_d = accept ? ST_FRESH : ST_EMPTY;
            ST_FRESH: begin
               if (E_allowin) begin
                  state_d = accept ? ST_FRESH : ST_EMPTY;
               end else begin
                  state_d     = ST_HELD;
                  inst_hold_d = inst_sram_rdata;
               end
            end
            ST_HELD: begin
               if (E_allowin) begin
                  state_d = accept ? ST_FRESH : ST_EMPTY;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= ST_EMPTY;
         pc_q        <= 32'h0;
         inst_hold_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         inst_hold_q <= inst_hold_d;
      end
   end

   assign d_inst   = (state_q == ST_HELD) ? inst_hold_q : inst_sram_rdata;
   assign DE_valid = d_valid && d_ready_go && rstn;
   assign DE_BUS   = {pc_q, d_inst};

`ifdef DECODE_PERF_EN
   logic [31:0] perf_issue_q;
   logic [31:0] perf_stall_q;
   logic        issue_ev;
   logic        stall_ev;

   // A flushed instruction is discarded, so it never counts as issued.
   assign issue_ev = DE_valid && E_allowin && !D_flush;
   assign stall_ev = DE_valid && !E_allowin;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         perf_issue_q <= 32'h0;
         perf_stall_q <= 32'h0;
      end else begin
         if (issue_ev) begin
            perf_issue_q <= perf_issue_q + 32'd1;
         end
         if (stall_ev) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_issue_cnt = perf_issue_q;
   assign perf_stall_cnt = perf_stall_q;
`else
   assign perf_issue_cnt = 32'h0;
   assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_decode_frontend.sv
// Self-checking bench for decode_frontend: directed vector table, counter wrap,
// then random traffic against an abstract one-entry model where inst = mem(pc).
module tb_decode_frontend;

`ifdef DECODE_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk;
   logic        rstn;
   logic        FD_valid;
   logic [32:0] FD_BUS;
   logic [31:0] inst_sram_rdata;
   logic        D_flush;
   logic        E_allowin;
   logic        D_allowin;
   logic        DE_valid;
   logic [63:0] DE_BUS;
   logic [31:0] perf_issue_cnt;
   logic [31:0] perf_stall_cnt;

   int n_pass  = 0;
   int n_total = 0;

   decode_frontend dut (
      .clk             (clk),
      .rstn            (rstn),
      .FD_valid        (FD_valid),
      .FD_BUS          (FD_BUS),
      .inst_sram_rdata (inst_sram_rdata),
      .D_flush         (D_flush),
      .E_allowin       (E_allowin),
      .D_allowin       (D_allowin),
      .DE_valid        (DE_valid),
      .DE_BUS          (DE_BUS),
      .perf_issue_cnt  (perf_issue_cnt),
      .perf_stall_cnt  (perf_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rstn;
      logic        fdv;
      logic        req;
      logic [31:0] pc;
      logic [31:0] rdata;
      logic        flush;
      logic        e;
      logic        dv;
      logic        al;
      logic        chk;
      logic [63:0] bus;
      logic [31:0] iss;
      logic [31:0] stl;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, fv, rq, input logic [31:0] p, rd,
                               input logic fl, e, dv, al, chk, input logic [63:0] bus,
                               input logic [31:0] iss, stl);
      vec_t v;
      v.rstn = r; v.fdv = fv; v.req = rq; v.pc = p; v.rdata = rd;
      v.flush = fl; v.e = e; v.dv = dv; v.al = al; v.chk = chk;
      v.bus = bus; v.iss = iss; v.stl = stl;
      return v;
   endfunction

   function automatic logic [31:0] mem(input logic [31:0] pc);
      return {pc[15:0], pc[31:16]} ^ 32'h1234_5678;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic drive(input logic r, fv, rq, input logic [31:0] p, rd, input logic fl, e);
      rstn = r; FD_valid = fv; FD_BUS = {p, rq}; inst_sram_rdata = rd;
      D_flush = fl; E_allowin = e;
   endtask

   logic        m_valid;
   logic [31:0] m_pc;
   logic [31:0] m_iss;
   logic [31:0] m_stl;
   logic        m_pacc;

   initial begin
      vec_t v;
      logic r_v, fv_v, rq_v, fl_v, e_v, allow, acc;
      logic [31:0] pc_v, rd_v;

      drive(0, 0, 0, 32'h0, 32'h0, 0, 0);
      //            rstn fv rq pc            rdata         fl e  dv al chk bus                      iss stl
      vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 1, 1, 64'h0,                    0, 0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 1, 0, 1, 1, 64'h0,                    0, 0));
      vecs.push_back(mk(1, 1, 1, 32'h1C000000, 32'h0,        0, 1, 0, 1, 0, 64'h0,                    0, 0));
      vecs.push_back(mk(1, 1, 1, 32'h1C000004, 32'h02800000, 0, 1, 1, 1, 1, 64'h1C000000_02800000,    0, 0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'h02800400, 0, 1, 1, 1, 1, 64'h1C000004_02800400,    1, 0));
      vecs.push_back(mk(1, 1, 1, 32'h1C000008, 32'h0,        0, 1, 0, 1, 0, 64'h0,                    2, 0));
      vecs.push_back(mk(1, 1, 1, 32'h1C00000C, 32'h03400000, 0, 0, 1, 0, 1, 64'h1C000008_03400000,    2, 0));
      vecs.push_back(mk(1, 1, 1, 32'h1C00000C, 32'hDEADBEEF, 0, 0, 1, 0, 1, 64'h1C000008_03400000,    2, 1));
      vecs.push_back(mk(1, 1, 1, 32'h1C00000C, 32'hDEADBEEF, 0, 0, 1, 0, 1, 64'h1C000008_03400000,    2, 2));
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'hDEADBEEF, 0, 1, 1, 1, 1, 64'h1C000008_03400000,    2, 3));
      vecs.push_back(mk(1, 1, 0, 32'h1C000010, 32'h0,        0, 1, 0, 1, 0, 64'h0,                    3, 3));
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 1, 0, 1, 1, 64'h1C000008_00000000,    3, 3));
      vecs.push_back(mk(1, 1, 1, 32'h1C000020, 32'h0,        0, 1, 0, 1, 0, 64'h0,                    3, 3));
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'h11111111, 0, 0, 1, 0, 1, 64'h1C000020_11111111,    3, 3));
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'h22222222, 0, 0, 1, 0, 1, 64'h1C000020_11111111,    3, 4));
      vecs.push_back(mk(1, 1, 1, 32'h1C000030, 32'h22222222, 1, 1, 1, 1, 1, 64'h1C000020_11111111,    3, 5));
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 1, 0, 1, 1, 64'h1C000020_00000000,    3, 5));
      vecs.push_back(mk(1, 1, 1, 32'h1C000040, 32'h0,        0, 1, 0, 1, 0, 64'h0,                    3, 5));
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'h33333333, 0, 0, 1, 0, 1, 64'h1C000040_33333333,    3, 5));
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 0, 1, 0, 1, 64'h1C000040_33333333,    3, 6));
      vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 1, 1, 64'h1C000040_33333333,    3, 7));
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 1, 0, 1, 1, 64'h0,                    0, 0));

      repeat (2) @(posedge clk);

      for (int k = 0; k < vecs.size(); k++) begin
         v = vecs[k];
         @(negedge clk);
         drive(v.rstn, v.fdv, v.req, v.pc, v.rdata, v.flush, v.e);
         #1;
         check($sformatf("t%0d de_valid", k), 64'(DE_valid), 64'(v.dv));
         check($sformatf("t%0d d_allowin", k), 64'(D_allowin), 64'(v.al));
         if (v.chk) check($sformatf("t%0d de_bus", k), DE_BUS, v.bus);
         check($sformatf("t%0d issue_cnt", k), 64'(perf_issue_cnt), 64'(PERF ? v.iss : 32'h0));
         check($sformatf("t%0d stall_cnt", k), 64'(perf_stall_cnt), 64'(PERF ? v.stl : 32'h0));
      end

`ifdef DECODE_PERF_EN
      @(negedge clk);
      force dut.perf_issue_q = 32'hFFFF_FFFF;
      drive(1, 1, 1, 32'h1C000100, 32'h0, 0, 1);
      #1;
      check("wrap preload", 64'(perf_issue_cnt), 64'hFFFF_FFFF);
      @(negedge clk);
      release dut.perf_issue_q;
      drive(1, 0, 0, 32'h0, 32'h0240_0000, 0, 1);
      #1;
      check("wrap issue valid", 64'(DE_valid), 64'h1);
      check("wrap before", 64'(perf_issue_cnt), 64'hFFFF_FFFF);
      @(negedge clk);
      drive(1, 0, 0, 32'h0, 32'h0, 0, 1);
      #1;
      check("wrap after", 64'(perf_issue_cnt), 64'h0);
`endif

      @(negedge clk);
      drive(0, 0, 0, 32'h0, 32'h0, 0, 1);
      repeat (2) @(negedge clk);
      m_valid = 1'b0; m_pc = 32'h0; m_iss = 32'h0; m_stl = 32'h0; m_pacc = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         r_v  = ($urandom_range(99) != 0);
         fv_v = ($urandom_range(9) < 7);
         rq_v = ($urandom_range(9) < 8);
         fl_v = ($urandom_range(99) < 8);
         e_v  = ($urandom_range(9) < 6);
         pc_v = $urandom;
         rd_v = m_pacc ? mem(m_pc) : $urandom;
         drive(r_v, fv_v, rq_v, pc_v, rd_v, fl_v, e_v);
         #1;
         check($sformatf("r%0d de_valid", i), 64'(DE_valid), 64'(m_valid & r_v));
         check($sformatf("r%0d d_allowin", i), 64'(D_allowin), 64'(!r_v | !m_valid | e_v));
         if (m_valid && r_v) check($sformatf("r%0d de_bus", i), DE_BUS, {m_pc, mem(m_pc)});
         check($sformatf("r%0d issue_cnt", i), 64'(perf_issue_cnt), 64'(m_iss));
         check($sformatf("r%0d stall_cnt", i), 64'(perf_stall_cnt), 64'(m_stl));

         allow = !r_v || !m_valid || e_v;
         acc   = fv_v && rq_v && allow && !fl_v;
         if (!r_v) begin
            m_valid = 1'b0; m_pc = 32'h0; m_iss = 32'h0; m_stl = 32'h0; m_pacc = 1'b0;
         end else begin
            if (PERF && m_valid && e_v && !fl_v) m_iss = m_iss + 32'd1;
            if (PERF && m_valid && !e_v) m_stl = m_stl + 32'd1;
            if (fl_v) m_valid = 1'b0;
            else if (allow) begin
               m_valid = acc;
               if (acc) m_pc = pc_v;
            end
            m_pacc = acc;
         end
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
